ripple_add_sequencer: RTL
=========================

# ripple_add_sequencer

Multi-cycle wide adder. It accepts two DATA_WIDTH operands plus carry-in over a valid/ready handshake and sequences one WORD_WIDTH ripple-carry adder across the operand words, least significant word first. The carry is registered between cycles, and the block returns the full sum and carry-out over a second valid/ready handshake. It sits between an operand producer and a result consumer wherever a wide add is needed but a full-width ripple chain would not meet timing or area.

## Interface
- DATA_WIDTH, 16, operand/sum width; must be a multiple of WORD_WIDTH
- WORD_WIDTH, 4, width of the shared ripple adder; one word is processed per cycle
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- din_a  in  DATA_WIDTH  operand A
- din_b  in  DATA_WIDTH  operand B
- din_ci  in  1  carry-in into word 0
- din_vld  in  1  operands valid
- din_rd  out  1  block can accept operands
- dout_s  out  DATA_WIDTH  sum
- dout_co  out  1  carry-out of the top word
- dout_vld  out  1  result valid
- dout_rd  in  1  consumer accepts result
- busy  out  1  operation in progress (state not IDLE)

## Operation
- NUM_WORDS = DATA_WIDTH/WORD_WIDTH. Word counter width is clog2(NUM_WORDS), minimum 1 bit.
- FSM states:
  - IDLE: din_rd=1. On din_vld, latch din_a, din_b into operand registers, load carry register with din_ci, set idx=0, go to RUN.
  - RUN: the word adder gets a[idx], b[idx] and the carry register. Its sum is written to sum register slice idx, and its carry-out is written to the carry register. idx increments. When idx==NUM_WORDS-1 is processed, go to DONE.
  - DONE: dout_vld=1. dout_s is the sum register; dout_co is the carry register. On dout_rd, go to IDLE.
- Arithmetic: {dout_co, dout_s} = din_a + din_b + din_ci, computed modulo 2^(DATA_WIDTH+1). There is no overflow flag.
- din_rd=0 in RUN and DONE; operands presented then are ignored, not queued.
- dout_s and dout_co are held stable while dout_vld=1 and dout_rd=0.
- Reset values: state IDLE, idx 0, operand/sum/carry registers 0. Hence dout_s=0, dout_co=0, dout_vld=0, busy=0, din_rd=1.
- Reset asserted mid-operation (RUN or DONE) abandons the operation immediately. No result is emitted and the block is in IDLE on release.
- NUM_WORDS==1 is legal: RUN lasts exactly one cycle.

## Timing
- Accept edge T0 (IDLE, din_vld=1). Word k is computed in the cycle after edge T0+k and registered at edge T0+k+1.
- dout_vld rises after edge T0+NUM_WORDS. Latency is NUM_WORDS cycles from acceptance to result valid.
- Result transfer at the edge where dout_vld=1 and dout_rd=1. din_rd is 1 from the next cycle.
- Peak throughput is one operation per NUM_WORDS+2 cycles (one IDLE, NUM_WORDS RUN, one DONE), with din_vld and dout_rd held high.
- din_rd, dout_vld and busy are decoded from state registers only. There is no combinational path from din_vld or dout_rd to any output.
- The critical path is one WORD_WIDTH ripple chain plus the input slice mux.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, DONE)
  - the NUM_WORDS derivation
  - the width-legality check (DATA_WIDTH % WORD_WIDTH == 0, else elaboration error)
- One sub-module, rca_word: a combinational WORD_WIDTH ripple-carry adder built from full-adder cells, with ports a, b, ci, s, co. It is instantiated exactly once.
- The top holds the FSM, the word counter, the operand/sum/carry registers, and the slice muxes.

## Test plan
- Basic add, DATA_WIDTH=16, WORD_WIDTH=4: a=0x1234, b=0x1111, ci=0 -> s=0x2345, co=0; dout_vld is exactly 4 cycles after accept.
- Carry through all words: a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1. Also a=0x00FF, b=0x0000, ci=1 -> s=0x0100, co=0.
- Backpressure:
  - Hold dout_rd=0 for 5 cycles in DONE -> dout_vld stays 1, dout_s/dout_co stay unchanged, din_rd=0.
  - A din_vld pulse with a=0xAAAA during this window is not accepted.
- Reset mid-operation: assert rst_n=0 in RUN at idx=2 -> outputs are at reset values immediately. After release, din_rd=1, and a new op 0x0F0F+0x0101 gives s=0x1010, co=0.
- Streaming: din_vld=1 and dout_rd=1 continuously with 1000 random operand sets, compared against a+b+ci -> all match, and results are spaced 6 cycles apart.
- Configuration sweep: DATA_WIDTH=8, WORD_WIDTH=8 (NUM_WORDS=1): a=0xFF, b=0xFF, ci=1 -> s=0xFF, co=1, with latency 1.

Source files
------------

// File: rtl/ripple_add_sequencer_pkg.sv
// Shared definitions for the multi-cycle wide adder: FSM states, word-count
// derivation and the operand/word width legality rule.
package ripple_add_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int num_words(input int data_width, input int word_width);
        return data_width / word_width;
    endfunction

    // A single-word configuration still needs a 1-bit counter.
    function automatic int idx_width(input int n_words);
        return (n_words > 1) ? $clog2(n_words) : 1;
    endfunction

    function automatic bit widths_legal(input int data_width, input int word_width);
        return (word_width > 0) && (data_width >= word_width) &&
               ((data_width % word_width) == 0);
    endfunction

endpackage

// File: rtl/ripple_add_sequencer_rca_word.sv
// Combinational WIDTH-bit ripple-carry adder assembled from full-adder cells.
module rca_word #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c_s[i];
        assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end

    assign co = c_s[WIDTH];

endmodule

// File: rtl/ripple_add_sequencer.sv
// Wide adder that reuses one WORD_WIDTH ripple adder across the operand words,
// least significant word first, with the carry held in a register between words.
module ripple_add_sequencer
    import ripple_add_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WORD_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] din_b,
    input  logic                  din_ci,
    input  logic                  din_vld,
    output logic                  din_rd,
    output logic [DATA_WIDTH-1:0] dout_s,
    output logic                  dout_co,
    output logic                  dout_vld,
    input  logic                  dout_rd,
    output logic                  busy
);

    localparam int NUM_WORDS = num_words(DATA_WIDTH, WORD_WIDTH);
    localparam int IDX_W     = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    if (!widths_legal(DATA_WIDTH, WORD_WIDTH)) begin : g_bad_widths
        $error("DATA_WIDTH must be a non-zero multiple of WORD_WIDTH");
    end

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  carry_q, carry_d;

    logic [WORD_WIDTH-1:0] a_word_s;
    logic [WORD_WIDTH-1:0] b_word_s;
    logic [WORD_WIDTH-1:0] s_word_s;
    logic                  co_word_s;

    // Operand slice muxes feeding the shared word adder.
    always_comb begin
        a_word_s = '0;
        b_word_s = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            a_word_s = (idx_q == IDX_W'(w)) ? a_q[w*WORD_WIDTH +: WORD_WIDTH] : a_word_s;
            b_word_s = (idx_q == IDX_W'(w)) ? b_q[w*WORD_WIDTH +: WORD_WIDTH] : b_word_s;
        end
    end

    rca_word #(
        .WIDTH (WORD_WIDTH)
    ) u_rca_word (
        .a  (a_word_s),
        .b  (b_word_s),
        .ci (carry_q),
        .s  (s_word_s),
        .co (co_word_s)
    );

    // Next-state logic: accept, sequence the words, then hold the result.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (din_vld) begin
                    a_d     = din_a;
                    b_d     = din_b;
                    carry_d = din_ci;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                carry_d = co_word_s;
                for (int w = 0; w < NUM_WORDS; w++) begin
                    sum_d[w*WORD_WIDTH +: WORD_WIDTH] = (idx_q == IDX_W'(w)) ?
                        s_word_s : sum_d[w*WORD_WIDTH +: WORD_WIDTH];
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (dout_rd) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, counter and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign din_rd   = (state_q == ST_IDLE);
    assign dout_vld = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);
    assign dout_s   = sum_q;
    assign dout_co  = carry_q;

endmodule
